// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect input and decode handshake.
// Perf counter ports exist only when FETCH_PERF_CNT_EN is defined.
interface instruction_fetch_unit_if;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        fetch_done_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  modport master (
    output instr_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, fetch_done_o,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetch_cnt_o, perf_stall_cnt_o,
`endif
    input  instr_i, redirect_i, redirect_pc_i, if_ready_i
  );

  modport slave (
    input  instr_addr_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, fetch_done_o,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetch_cnt_o, perf_stall_cnt_o,
`endif
    output instr_i, redirect_i, redirect_pc_i, if_ready_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures {instr, pc} into a small FIFO, feeds decode.
// Optional fetch/stall performance counters are enabled with FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 65
) (
  input logic                       clk_i,
  input logic                       rst_i,
  instruction_fetch_unit_if.master  bus
);
  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W    = $clog2(DEPTH + 1);
  localparam logic [32:0]     PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic in_range, valid, pop, push;

  // 33-bit compare keeps the limit unsigned even for large memories
  assign in_range = ({1'b0, pc_reg} < PC_LIMIT);
  assign valid    = (count_reg != '0) & ~bus.redirect_i;
  assign pop      = valid & bus.if_ready_i;
  assign push     = in_range & ((count_reg != FULL) | pop) & ~bus.redirect_i;

  always_comb begin
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (bus.redirect_i) begin
      pc_next     = {bus.redirect_pc_i[31:2], 2'b00};
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Entries are cleared on reset so the head outputs are defined while empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_reg] <= bus.instr_i;
      pc_mem[wr_ptr_reg]    <= pc_reg;
    end
  end

  assign bus.instr_addr_o  = pc_reg;
  assign bus.if_valid_o    = valid;
  assign bus.if_instr_o    = instr_mem[rd_ptr_reg];
  assign bus.if_pc_o       = pc_mem[rd_ptr_reg];
  assign bus.if_pc_plus4_o = pc_mem[rd_ptr_reg] + 32'd4;
  assign bus.fetch_done_o  = ~in_range & (count_reg == '0);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if ((count_reg == FULL) & ~pop & ~bus.redirect_i)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt_o = fetch_cnt_reg;
  assign bus.perf_stall_cnt_o = stall_cnt_reg;
`endif
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that sits directly upstream of the instruction memory and downstream-feeds the decode stage. Owns the program counter, drives the word address into the combinational instruction memory, captures each returned instruction with its PC into a small FIFO, and presents it to decode over a valid/ready handshake. Control-flow redirects from later stages flush the FIFO and reload the PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `DEPTH`, 2: FIFO entries; power of two, 2..8.
- `IMEM_WORDS`, 65: instruction memory size in 32-bit words; fetch halts at `PC >= IMEM_WORDS*4`.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `instr_addr_o`  out  32  byte address to instruction memory; always equals current PC.
- `instr_i`  in  32  instruction word from memory; combinational response to `instr_addr_o` in the same cycle.
- `redirect_i`  in  1  flush and reload PC, e.g. taken branch or jump.
- `redirect_pc_i`  in  32  new PC; bits [1:0] are forced to 0.
- `if_valid_o`  out  1  FIFO head holds a valid instruction.
- `if_ready_i`  in  1  decode accepts the head this cycle.
- `if_instr_o`  out  32  head instruction.
- `if_pc_o`  out  32  PC of the head instruction.
- `if_pc_plus4_o`  out  32  `if_pc_o + 4`, modulo 2^32.
- `fetch_done_o`  out  1  PC is past the end of memory and the FIFO is empty.

## Operation
- State: `pc` (32 bits), FIFO of `DEPTH` entries holding {instr, pc}, plus rd/wr pointers and `count` (0..DEPTH).
- `pop = if_valid_o & if_ready_i`.
- `in_range = (pc < IMEM_WORDS*4)`, compared unsigned.
- `push = in_range & (count < DEPTH | pop) & ~redirect_i`.
  - A push writes {`instr_i`, `pc`} at the tail.
  - It also updates `pc <= pc + 4`; wraps modulo 2^32, though wrap is unreachable in practice because of `in_range`.
- Push and pop in the same cycle when full: both happen and `count` is unchanged.
- Empty FIFO: `if_valid_o = 0`. Head outputs are don't-care but must be stable, not X, after reset.
- `redirect_i = 1` has the highest priority:
  - `count <= 0` and pointers reset.
  - `pc <= {redirect_pc_i[31:2], 2'b00}`.
  - No push that cycle.
  - `if_valid_o` is forced to 0 combinationally, so no pop occurs.
- Out of range (`in_range = 0`): no push. The PC holds and the FIFO drains normally.
- `fetch_done_o = ~in_range & (count == 0)`. A redirect to an in-range PC clears it.
- Reset, including mid-operation: `pc = RESET_PC`, `count = 0`, `if_valid_o = 0`, `if_instr_o = 0`, `if_pc_o = 0`, `if_pc_plus4_o = 4`. `fetch_done_o` is reset-valued from `RESET_PC` against `IMEM_WORDS`.

## Timing
- Fetch-to-valid latency is 1 cycle: an instruction pushed at edge N is visible with `if_valid_o = 1` after edge N.
- First valid after reset: the first rising edge after `rst_i` falls pushes `RESET_PC`, and valid is high after that edge.
- Redirect asserted in cycle N:
  - PC equals the target after edge N.
  - Target is pushed at edge N+1 and valid after edge N+1.
  - Decode therefore sees exactly one empty cycle, the cycle after the redirect edge.
- Sustained throughput is one instruction per cycle while `if_ready_i = 1`.
- Backpressure: `if_ready_i = 0` with `count == DEPTH` holds the PC and all FIFO contents unchanged.
- Head outputs come only from registers. `if_valid_o` additionally depends combinationally on `redirect_i`.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two ports, both reset to 0 and both wrapping at 2^32:
  - `perf_fetch_cnt_o` (out, 32): increments on every push.
  - `perf_stall_cnt_o` (out, 32): increments on every cycle with `count == DEPTH & ~pop & ~redirect_i`.
- Without the macro, neither port nor counter exists and behaviour is otherwise identical.

## Test plan
- Reset release with `if_ready_i = 1` and memory words 0..4 = A..E: `if_instr_o` shows A, B, C, D, E on consecutive cycles; `if_pc_o` shows 0, 4, 8, 12, 16; `if_pc_plus4_o` shows 4, 8, 12, 16, 20.
- `if_ready_i = 0` for 5 cycles from reset:
  - FIFO fills to 2 entries holding A and B; `instr_addr_o` holds at 8.
  - On release, decode sees A, B, C back-to-back with no gap.
  - With the macro defined, `perf_stall_cnt_o = 3`.
- Redirect to `0x0000_0043` while FIFO full:
  - `if_valid_o` drops in the same cycle; PC becomes 0x40 after the edge.
  - Next valid is word 16 with `if_pc_o = 0x40`, after exactly one empty cycle.
- Run to end with `IMEM_WORDS = 65`:
  - Last valid has `if_pc_o = 0x100`; `instr_addr_o` holds at 0x104.
  - `fetch_done_o` rises the cycle after that last pop.
  - A redirect to 0 clears `fetch_done_o`.
- Assert `rst_i` asynchronously mid-stream, between edges, with FIFO full: outputs take their reset values immediately, and fetch restarts from `RESET_PC` after release.
- Simultaneous push and pop at `count == DEPTH` for 10 cycles: `count` stays at 2 and the instruction order is preserved with no duplicates or drops.
